// File: rtl/unit_output_tx_if.sv
// Core/arbiter-side bundle of the unit output transmitter.
//   master : drives wr_en/wr_addr/wr_data/commit (core) and rd_en (arbiter),
//            observes busy/dout/empty/err
//   slave  : the transmitter itself
interface unit_output_tx_if #(
  parameter int unsigned UNIT_OUTPUT_WIDTH = 4,
  parameter int unsigned PKT_NUM_WORDS     = 20
);
  localparam int unsigned AddrW = (PKT_NUM_WORDS > 1) ? $clog2(PKT_NUM_WORDS) : 1;

  logic                         wr_en;
  logic [AddrW-1:0]             wr_addr;
  logic [15:0]                  wr_data;
  logic                         commit;
  logic                         busy;
  logic [UNIT_OUTPUT_WIDTH-1:0] dout;
  logic                         rd_en;
  logic                         empty;
  logic [1:0]                   err;

  modport master (
    output wr_en, wr_addr, wr_data, commit, rd_en,
    input  busy, dout, empty, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit, rd_en,
    output busy, dout, empty, err
  );
endinterface

// File: rtl/unit_output_tx.sv
// Unit-side transmitter of the computing-unit output packet.
// The core fills PKT_NUM_WORDS 16-bit words into a local buffer and commits;
// the arbiter then sees a FIFO-like port (dout/rd_en/empty). One rd_en pulse
// streams an all-ones header, the payload (word 0 first, low chunk first,
// UNIT_OUTPUT_WIDTH bits per cycle) and a single zero trailer cycle.
//
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   bus.wr_en/wr_addr/wr_data  payload word write (ignored while busy)
//   bus.commit  buffer complete, packet becomes available
//   bus.busy    buffer owned by transmitter
//   bus.dout    registered output stream
//   bus.rd_en   arbiter read request pulse
//   bus.empty   no packet available
//   bus.err     sticky [0] write/commit while busy, [1] rd_en while empty
//
// Build option: define UNIT_OUTPUT_DBL_BUF_EN for two ping-pong buffers, letting
// the core fill the next packet while the current one streams.
module unit_output_tx #(
  parameter int unsigned UNIT_OUTPUT_WIDTH = 4,
  parameter int unsigned PKT_NUM_WORDS     = 20
) (
  input logic              CLK,
  input logic              RST_N,
  unit_output_tx_if.slave  bus
);
  localparam int unsigned W      = UNIT_OUTPUT_WIDTH;
  localparam int unsigned C      = 16 / W;
  localparam int unsigned ChunkW = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned AddrW  = (PKT_NUM_WORDS > 1) ? $clog2(PKT_NUM_WORDS) : 1;
  localparam logic [ChunkW-1:0] LastChunk = ChunkW'(C - 1);
  localparam logic [AddrW-1:0]  LastWord  = AddrW'(PKT_NUM_WORDS - 1);

  typedef enum logic [2:0] {StIdle, StReady, StHeader, StStream, StTrail} state_e;

  state_e            state_q, state_d;
  logic [ChunkW-1:0] chunk_q, chunk_d;
  logic [AddrW-1:0]  word_q, word_d;
  logic [W-1:0]      dout_q, dout_d;
  logic [1:0]        err_q, err_d;

  logic        busy, empty, wr_ok, commit_ok, rd_ok, last_chunk;
  logic [15:0] cur_word;
  logic [W-1:0] chunk_data;

`ifdef UNIT_OUTPUT_DBL_BUF_EN
  logic [15:0] mem_q [2][PKT_NUM_WORDS];
  logic [1:0]  own_q, own_d;       // buffer committed or streaming
  logic        wr_sel_q, wr_sel_d; // buffer the core writes into
  logic        rd_sel_q, rd_sel_d; // buffer being streamed
  logic        pend_q, pend_d;     // packet committed while another streams

  assign busy     = own_q[wr_sel_q];
  assign cur_word = mem_q[rd_sel_q][word_q];

  always_ff @(posedge CLK) begin
    if (wr_ok) mem_q[wr_sel_q][bus.wr_addr] <= bus.wr_data;
  end
`else
  logic [15:0] mem_q [PKT_NUM_WORDS];

  assign busy     = (state_q != StIdle);
  assign cur_word = mem_q[word_q];

  always_ff @(posedge CLK) begin
    if (wr_ok) mem_q[bus.wr_addr] <= bus.wr_data;
  end
`endif

  assign empty      = (state_q != StReady);
  assign wr_ok      = bus.wr_en & ~busy;
  assign commit_ok  = bus.commit & ~busy;
  assign rd_ok      = bus.rd_en & ~empty;
  assign last_chunk = (chunk_q == LastChunk) && (word_q == LastWord);
  assign chunk_data = cur_word[W*chunk_q +: W];

  // dout is loaded one cycle ahead: HEADER loads chunk 0, the state that
  // loads the final chunk moves to TRAIL, and TRAIL loads the zero trailer.
  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    word_d  = word_q;
    dout_d  = '0;
    err_d   = err_q;
    if ((bus.wr_en || bus.commit) && busy) err_d[0] = 1'b1;
    if (bus.rd_en && !rd_ok)               err_d[1] = 1'b1;
`ifdef UNIT_OUTPUT_DBL_BUF_EN
    own_d    = own_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    pend_d   = pend_q;
    if (commit_ok) own_d[wr_sel_q] = 1'b1;
`endif
    unique case (state_q)
      StIdle: begin
        if (commit_ok) state_d = StReady;
      end
      StReady: begin
        if (rd_ok) begin
          state_d = StHeader;
          dout_d  = '1;
          chunk_d = '0;
          word_d  = '0;
`ifdef UNIT_OUTPUT_DBL_BUF_EN
          // Ready packet always sits in the write buffer; hand the core the other.
          rd_sel_d = wr_sel_q;
          wr_sel_d = ~wr_sel_q;
`endif
        end
      end
      StHeader, StStream: begin
        dout_d = chunk_data;
        // With C == 1 the compare is always true, so chunk_q stays 0.
        if (chunk_q == LastChunk) begin
          chunk_d = '0;
          word_d  = last_chunk ? '0 : word_q + AddrW'(1);
        end else begin
          chunk_d = chunk_q + ChunkW'(1);
        end
        state_d = last_chunk ? StTrail : StStream;
`ifdef UNIT_OUTPUT_DBL_BUF_EN
        if (commit_ok) pend_d = 1'b1;
`endif
      end
      StTrail: begin
`ifdef UNIT_OUTPUT_DBL_BUF_EN
        own_d[rd_sel_q] = 1'b0;
        pend_d          = 1'b0;
        state_d         = (pend_q || commit_ok) ? StReady : StIdle;
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      chunk_q <= '0;
      word_q  <= '0;
      dout_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      word_q  <= word_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

`ifdef UNIT_OUTPUT_DBL_BUF_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      own_q    <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      own_q    <= own_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      pend_q   <= pend_d;
    end
  end
`endif

  assign bus.dout  = dout_q;
  assign bus.busy  = busy;
  assign bus.empty = empty;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_unit_output_tx.sv
module tb_unit_output_tx;
  localparam int unsigned W  = 4;
  localparam int unsigned N  = 20;
  localparam int unsigned C  = 16 / W;
  localparam int unsigned AW = $clog2(N);
  localparam logic [31:0] ChunkMask = (32'd1 << W) - 1;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  unit_output_tx_if #(.UNIT_OUTPUT_WIDTH(W),  .PKT_NUM_WORDS(N)) bus ();
  unit_output_tx_if #(.UNIT_OUTPUT_WIDTH(1),  .PKT_NUM_WORDS(N)) bus1 ();
  unit_output_tx_if #(.UNIT_OUTPUT_WIDTH(16), .PKT_NUM_WORDS(N)) bus16 ();

  unit_output_tx #(.UNIT_OUTPUT_WIDTH(W),  .PKT_NUM_WORDS(N)) dut   (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  unit_output_tx #(.UNIT_OUTPUT_WIDTH(1),  .PKT_NUM_WORDS(N)) dut1  (.CLK(CLK), .RST_N(RST_N), .bus(bus1));
  unit_output_tx #(.UNIT_OUTPUT_WIDTH(16), .PKT_NUM_WORDS(N)) dut16 (.CLK(CLK), .RST_N(RST_N), .bus(bus16));

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: buffer image, ownership and sticky error bits.
  logic [15:0] exp_mem [N];
  logic [31:0] exp_q [$];
  bit          model_busy = 1'b0;
  logic [1:0]  exp_err = 2'b00;

  typedef struct packed {
    logic          wr;
    logic          cm;
    logic          rd;
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic          busy;
    logic          empty;
    logic [1:0]    err;
    logic [W-1:0]  dout;
  } vec_t;

  vec_t tbl [7];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input logic wr, input logic cm, input logic rd,
                              input int a, input logic [15:0] d, input logic b,
                              input logic e, input logic [1:0] er);
    vec_t v;
    v.wr = wr; v.cm = cm; v.rd = rd; v.addr = AW'(a); v.data = d;
    v.busy = b; v.empty = e; v.err = er; v.dout = '0;
    return v;
  endfunction

  function automatic logic [15:0] rnd_word();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] wide_pat(input int i);
    case (i % 4)
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      2:       return 16'h0001;
      default: return 16'h8000;
    endcase
  endfunction

  // Expected stream: each word split low chunk first.
  function automatic void build_q();
    exp_q.delete();
    for (int j = 0; j < N; j++)
      for (int k = 0; k < C; k++)
        exp_q.push_back((32'(exp_mem[j]) >> (k * W)) & ChunkMask);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_word(input int a, input logic [15:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    if (model_busy) exp_err[0] = 1'b1;
    else            exp_mem[a] = d;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
    model_busy = 1'b1;
  endtask

  task automatic payload_check(input string tag);
    for (int i = 0; i < N * C; i++) begin
      tick();
      check($sformatf("%s_chunk%0d", tag, i), 32'(bus.dout), exp_q[i]);
    end
  endtask

  // Waits `delay` cycles with a ready packet, reads it and checks the whole frame.
  task automatic stream_packet(input int delay, input string tag);
    for (int d = 0; d < delay; d++) begin
      tick();
      check({tag, "_wait_empty"}, 32'(bus.empty), 32'd0);
      check({tag, "_wait_dout"},  32'(bus.dout),  32'd0);
    end
    build_q();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check({tag, "_header"}, 32'(bus.dout), ChunkMask);
    check({tag, "_empty_after_rd"}, 32'(bus.empty), 32'd1);
    payload_check(tag);
    tick();
    check({tag, "_trailer"}, 32'(bus.dout), 32'd0);
    tick();
    check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, "_dout_end"}, 32'(bus.dout), 32'd0);
    model_busy = 1'b0;
  endtask

  task automatic wide_set(input logic wr, input logic cm, input logic rd, input int a,
                          input logic [15:0] d);
    bus1.wr_en = wr;  bus1.commit = cm;  bus1.rd_en = rd;  bus1.wr_addr = AW'(a);
    bus1.wr_data = d;
    bus16.wr_en = wr; bus16.commit = cm; bus16.rd_en = rd; bus16.wr_addr = AW'(a);
    bus16.wr_data = d;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.commit = 1'b0; bus.rd_en = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0;
    wide_set(1'b0, 1'b0, 1'b0, 0, 16'h0);

    // Reset values
    #2;
    check("rst_dout",  32'(bus.dout),  32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_err",   32'(bus.err),   32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();

    // Basic packet
    for (int i = 0; i < N; i++) write_word(i, 16'h1000 + 16'(i));
    do_commit();
    check("basic_busy_commit",  32'(bus.busy),  32'd1);
    check("basic_empty_commit", 32'(bus.empty), 32'd0);
    check("basic_dout_ready",   32'(bus.dout),  32'd0);
    stream_packet(2, "basic");

    // Arbiter holds off for 50 cycles
    do_commit();
    stream_packet(50, "delay");

    // Misuse table, then the packet it leaves behind
    tbl[0] = mk(0, 0, 0, 0, 16'h0000, 0, 1, 2'b00);
    tbl[1] = mk(1, 0, 0, 3, 16'h3333, 0, 1, 2'b00);
    tbl[2] = mk(0, 0, 1, 0, 16'h0000, 0, 1, 2'b10);
    tbl[3] = mk(1, 1, 0, 4, 16'h4444, 1, 0, 2'b10);
    tbl[4] = mk(1, 0, 0, 3, 16'hDEAD, 1, 0, 2'b11);
    tbl[5] = mk(0, 1, 0, 0, 16'h0000, 1, 0, 2'b11);
    tbl[6] = mk(0, 0, 0, 0, 16'h0000, 1, 0, 2'b11);
    for (int r = 0; r < 7; r++) begin
      bus.wr_en = tbl[r].wr; bus.commit = tbl[r].cm; bus.rd_en = tbl[r].rd;
      bus.wr_addr = tbl[r].addr; bus.wr_data = tbl[r].data;
      tick();
      bus.wr_en = 1'b0; bus.commit = 1'b0; bus.rd_en = 1'b0;
      check($sformatf("tbl%0d_busy", r),  32'(bus.busy),  32'(tbl[r].busy));
      check($sformatf("tbl%0d_empty", r), 32'(bus.empty), 32'(tbl[r].empty));
      check($sformatf("tbl%0d_err", r),   32'(bus.err),   32'(tbl[r].err));
      check($sformatf("tbl%0d_dout", r),  32'(bus.dout),  32'(tbl[r].dout));
    end
    exp_mem[3] = 16'h3333;
    exp_mem[4] = 16'h4444;
    model_busy = 1'b1;
    exp_err    = 2'b11;
    stream_packet(0, "misuse");
    check("misuse_err_sticky", 32'(bus.err), 32'(exp_err));

    // Randomized packets against the model
    for (int p = 0; p < 6; p++) begin
      int nw;
      int a;
      logic [15:0] d;
      nw = $urandom_range(1, N);
      if ($urandom_range(0, 2) == 0) begin
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        exp_err[1] = 1'b1;
        check("rnd_rd_empty_dout",  32'(bus.dout),  32'd0);
        check("rnd_rd_empty_empty", 32'(bus.empty), 32'd1);
      end
      for (int k = 0; k < nw - 1; k++) write_word($urandom_range(0, N - 1), rnd_word());
      a = $urandom_range(0, N - 1);
      d = rnd_word();
      bus.wr_en = 1'b1; bus.commit = 1'b1; bus.wr_addr = AW'(a); bus.wr_data = d;
      tick();
      bus.wr_en = 1'b0; bus.commit = 1'b0;
      exp_mem[a] = d;
      model_busy = 1'b1;
      check("rnd_busy_commit",  32'(bus.busy),  32'd1);
      check("rnd_empty_commit", 32'(bus.empty), 32'd0);
      if ($urandom_range(0, 1) == 1) write_word($urandom_range(0, N - 1), rnd_word());
      stream_packet($urandom_range(0, 6), "rnd");
    end
    check("rnd_err", 32'(bus.err), 32'(exp_err));

    // Reset in the middle of the stream
    for (int i = 0; i < N; i++) write_word(i, 16'hFFFF - 16'(i));
    do_commit();
    build_q();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("rstmid_header", 32'(bus.dout), ChunkMask);
    for (int i = 0; i <= 37; i++) begin
      tick();
      check($sformatf("rstmid_chunk%0d", i), 32'(bus.dout), exp_q[i]);
    end
    #2;
    RST_N = 1'b0;
    #1;
    check("rstmid_dout",  32'(bus.dout),  32'd0);
    check("rstmid_empty", 32'(bus.empty), 32'd1);
    check("rstmid_busy",  32'(bus.busy),  32'd0);
    check("rstmid_err",   32'(bus.err),   32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    model_busy = 1'b0;
    exp_err    = 2'b00;
    for (int i = 0; i < N; i++) write_word(i, rnd_word());
    do_commit();
    stream_packet(1, "post_rst");

`ifdef UNIT_OUTPUT_DBL_BUF_EN
    // Packet B filled and committed while A streams
    for (int i = 0; i < N; i++) write_word(i, rnd_word());
    do_commit();
    build_q();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("dbl_a_header", 32'(bus.dout), ChunkMask);
    check("dbl_busy_hdr", 32'(bus.busy), 32'd0);
    model_busy = 1'b0;
    fork
      payload_check("dbl_a");
      begin
        for (int i = 0; i < N; i++) write_word(i, rnd_word());
        do_commit();
        check("dbl_busy_b", 32'(bus.busy), 32'd1);
      end
    join
    tick();
    check("dbl_gap_dout",  32'(bus.dout),  32'd0);
    check("dbl_gap_empty", 32'(bus.empty), 32'd0);
    stream_packet(0, "dbl_b");
`endif

    // Width 1 and 16, all-ones / all-zero / single-bit words
    for (int i = 0; i < N; i++) begin
      wide_set(1'b1, 1'b0, 1'b0, i, wide_pat(i));
      tick();
    end
    wide_set(1'b0, 1'b1, 1'b0, 0, 16'h0);
    tick();
    wide_set(1'b0, 1'b0, 1'b1, 0, 16'h0);
    tick();
    wide_set(1'b0, 1'b0, 1'b0, 0, 16'h0);
    check("w1_header",  32'(bus1.dout),  32'h1);
    check("w16_header", 32'(bus16.dout), 32'hFFFF);
    for (int i = 0; i <= N * 16; i++) begin
      tick();
      if (i < N * 16)
        check($sformatf("w1_bit%0d", i), 32'(bus1.dout),
              (32'(wide_pat(i / 16)) >> (i % 16)) & 32'h1);
      else
        check("w1_trailer", 32'(bus1.dout), 32'd0);
      if (i < N)
        check($sformatf("w16_word%0d", i), 32'(bus16.dout), 32'(wide_pat(i)));
      else if (i == N)
        check("w16_trailer", 32'(bus16.dout), 32'd0);
    end
    tick();
    check("w1_busy_end",  32'(bus1.busy),  32'd0);
    check("w16_busy_end", 32'(bus16.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
